// File: rtl/peripheral_pkg.sv
// peripheral_pkg: shared types, constants and the IEEE-754 class decoder
package peripheral_pkg;
    typedef enum logic [0:0] {EMPTY = 1'b0, SHOW = 1'b1} state_t;
    localparam int NUM_BYTES   = 4;
    localparam int FLAG_SIGN   = 4;
    localparam int FLAG_NAN    = 3;
    localparam int FLAG_INF    = 2;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_DENORM = 0;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    function automatic logic [4:0] classify(input logic [31:0] w);
        logic [7:0]  exp;
        logic [22:0] man;
        logic [4:0]  f;
        exp = w[30:23];
        man = w[22:0];
        f = '0;
        f[FLAG_SIGN]   = w[31];
        f[FLAG_NAN]    = (exp == EXP_ALL_ONES) && (man != '0);
        f[FLAG_INF]    = (exp == EXP_ALL_ONES) && (man == '0);
        f[FLAG_ZERO]   = (exp == '0) && (man == '0);
        f[FLAG_DENORM] = (exp == '0) && (man != '0);
        return f;
    endfunction
endpackage

// File: rtl/peripheral_scrolltick.sv
// peripheral_scrolltick: free-running step timer, one-cycle tick every SCROLL_TICKS enabled cycles
module peripheral_scrolltick #(
    parameter int SCROLL_TICKS = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = (SCROLL_TICKS > 2) ? $clog2(SCROLL_TICKS) : 1;
    localparam logic [W-1:0] LAST = W'(SCROLL_TICKS - 1);

    logic [W-1:0] r_count;
    logic         w_last;

    assign w_last = (r_count == LAST);
    assign tick   = enable && !clear && w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (clear || !enable || w_last)
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end
endmodule

// File: rtl/peripheral_showresult.sv
// peripheral_showresult: holds the multiplier product and shows it byte by byte with its IEEE-754 class
module peripheral_showresult
    import peripheral_pkg::*;
#(
    parameter int SCROLL_TICKS = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] result,
    input  logic        resultvalid,
    input  logic        nextpulse,
    input  logic        clearpulse,
    input  logic        autoscroll,
    output logic [7:0]  dataout,
    output logic [3:0]  byteselect_o,
    output logic        ready,
    output logic [4:0]  flags_o
);
    state_t      r_state;
    logic [31:0] r_held;
    logic [1:0]  r_ptr;
    logic [4:0]  r_flags;
    logic        w_show;
    logic        w_tick;
    logic        w_advance;

    assign w_show    = (r_state == SHOW);
    assign w_advance = w_show && (nextpulse || w_tick);

    peripheral_scrolltick #(.SCROLL_TICKS(SCROLL_TICKS)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (w_show && autoscroll),
        .clear  (nextpulse || resultvalid),
        .tick   (w_tick)
    );

    // capture outranks clear, which outranks advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_held  <= '0;
            r_ptr   <= '0;
            r_flags <= '0;
        end else if (resultvalid) begin
            r_state <= SHOW;
            r_held  <= result;
            r_ptr   <= 2'(NUM_BYTES - 1);
            r_flags <= classify(result);
        end else if (clearpulse && w_show) begin
            r_state <= EMPTY;
            r_held  <= '0;
            r_ptr   <= '0;
            r_flags <= '0;
        end else if (w_advance) begin
            r_ptr   <= r_ptr - 1'b1;
        end
    end

    assign dataout      = r_held[{r_ptr, 3'b000} +: 8];
    assign byteselect_o = w_show ? (4'b0001 << r_ptr) : 4'b0000;
    assign ready        = w_show;
    assign flags_o      = r_flags;
endmodule

// File: tb/tb_peripheral_showresult.sv
// tb_peripheral_showresult: directed scoreboard bench for the result display peripheral
module tb_peripheral_showresult;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] result = '0;
    logic        resultvalid = 1'b0;
    logic        nextpulse = 1'b0;
    logic        clearpulse = 1'b0;
    logic        autoscroll = 1'b0;
    logic [7:0]  dataout;
    logic [3:0]  byteselect_o;
    logic        ready;
    logic [4:0]  flags_o;

    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;
    exp_t q[$];
    int n_pass = 0;
    int n_total = 0;

    peripheral_showresult #(.SCROLL_TICKS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .resultvalid  (resultvalid),
        .nextpulse    (nextpulse),
        .clearpulse   (clearpulse),
        .autoscroll   (autoscroll),
        .dataout      (dataout),
        .byteselect_o (byteselect_o),
        .ready        (ready),
        .flags_o      (flags_o)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [7:0] d, input logic [3:0] s,
                              input logic r, input logic [4:0] f);
        exp_t e;
        e.tag = tag;
        e.v = {d, s, r, f};
        q.push_back(e);
    endtask

    task automatic compare;
        exp_t e;
        logic [17:0] obs;
        e = q.pop_front();
        obs = {dataout, byteselect_o, ready, flags_o};
        n_total++;
        assert (obs === e.v) n_pass++;
        else $error("FAIL %s: observed d=%h s=%b r=%b f=%b, expected d=%h s=%b r=%b f=%b",
                    e.tag, obs[17:10], obs[9:6], obs[5], obs[4:0],
                    e.v[17:10], e.v[9:6], e.v[5], e.v[4:0]);
    endtask

    task automatic step(input string tag, input logic rv, input logic [31:0] res,
                        input logic np, input logic cp, input logic [7:0] d,
                        input logic [3:0] s, input logic r, input logic [4:0] f);
        resultvalid = rv;
        result      = res;
        nextpulse   = np;
        clearpulse  = cp;
        expect_out(tag, d, s, r, f);
        @(posedge clk);
        #1;
        resultvalid = 1'b0;
        nextpulse   = 1'b0;
        clearpulse  = 1'b0;
        compare();
    endtask

    task automatic cap(input string tag, input logic [31:0] res, input logic [4:0] f);
        step(tag, 1'b1, res, 1'b0, 1'b0, res[31:24], 4'b1000, 1'b1, f);
    endtask

    task automatic idle(input string tag, input int n, input logic [7:0] d, input logic [3:0] s);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 32'h0, 1'b0, 1'b0, d, s, 1'b1, 5'b00000);
    endtask

    initial begin
        #12;
        expect_out("reset_state", 8'h00, 4'b0000, 1'b0, 5'b0);
        compare();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cap("cap_pi", 32'h40490FDB, 5'b00000);
        step("next_b2", 0, 0, 1, 0, 8'h49, 4'b0100, 1, 5'b0);
        step("next_b1", 0, 0, 1, 0, 8'h0F, 4'b0010, 1, 5'b0);
        step("next_b0", 0, 0, 1, 0, 8'hDB, 4'b0001, 1, 5'b0);
        step("next_wrap", 0, 0, 1, 0, 8'h40, 4'b1000, 1, 5'b0);
        cap("cap_inf", 32'h7F800000, 5'b00100);
        cap("cap_nan", 32'hFFC00000, 5'b11000);
        cap("cap_negzero", 32'h80000000, 5'b10010);
        cap("cap_denorm", 32'h00000001, 5'b00001);
        autoscroll = 1'b1;
        cap("scroll_cap", 32'h11223344, 5'b00000);
        idle("scroll_hold3", 3, 8'h11, 4'b1000);
        idle("scroll_b2", 1, 8'h22, 4'b0100);
        idle("scroll_hold2", 3, 8'h22, 4'b0100);
        idle("scroll_b1", 1, 8'h33, 4'b0010);
        idle("scroll_hold1", 3, 8'h33, 4'b0010);
        idle("scroll_b0", 1, 8'h44, 4'b0001);
        idle("scroll_hold0", 3, 8'h44, 4'b0001);
        idle("scroll_wrap", 1, 8'h11, 4'b1000);
        idle("scroll_mid", 1, 8'h11, 4'b1000);
        step("scroll_next", 0, 0, 1, 0, 8'h22, 4'b0100, 1, 5'b0);
        idle("scroll_restart_hold", 3, 8'h22, 4'b0100);
        idle("scroll_restart_step", 1, 8'h33, 4'b0010);
        autoscroll = 1'b0;
        step("cap_over_clear", 1, 32'hAABBCCDD, 0, 1, 8'hAA, 4'b1000, 1, 5'b10000);
        step("clear", 0, 0, 0, 1, 8'h00, 4'b0000, 0, 5'b0);
        step("next_empty", 0, 0, 1, 0, 8'h00, 4'b0000, 0, 5'b0);
        cap("cap_pre_rst", 32'h40490FDB, 5'b00000);
        step("pre_rst_b2", 0, 0, 1, 0, 8'h49, 4'b0100, 1, 5'b0);
        step("pre_rst_b1", 0, 0, 1, 0, 8'h0F, 4'b0010, 1, 5'b0);
        #2;
        reset = 1'b0;
        #1;
        expect_out("async_reset", 8'h00, 4'b0000, 1'b0, 5'b0);
        compare();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cap("cap_after_rst", 32'h3F800000, 5'b00000);
        step("one_b2", 0, 0, 1, 0, 8'h80, 4'b0100, 1, 5'b0);
        step("one_b1", 0, 0, 1, 0, 8'h00, 4'b0010, 1, 5'b0);
        step("one_b0", 0, 0, 1, 0, 8'h00, 4'b0001, 1, 5'b0);
        step("cap_over_next", 1, 32'h12345678, 1, 0, 8'h12, 4'b1000, 1, 5'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/peripheral_showresult.md
# peripheral_showresult

Output-side peripheral of the IEEE-754 multiplier board design: it captures the 32-bit product from the multiplier core and presents it one byte at a time on an 8-bit display/LED bus, stepping with the board's enter/next button pulse or an optional auto-scroll timer. It also reports the IEEE-754 class of the captured word. It mirrors the byte-wise operand entry path: the operand loader writes bytes into registers, and this block reads bytes out of a register using the same one-hot byte-select encoding.

## Interface
Parameters:
- SCROLL_TICKS, 50_000_000: clock cycles per auto-scroll step (1 s at 50 MHz); must be ≥ 2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- result  in  32  product word from the multiplier core.
- resultvalid  in  1  one-cycle strobe; `result` is valid in that cycle.
- nextpulse  in  1  one-cycle debounced button pulse; advances the byte pointer.
- clearpulse  in  1  one-cycle pulse; discards the held result.
- autoscroll  in  1  level; 1 enables timed byte advance.
- dataout  out  8  currently selected byte of the held result.
- byteselect_o  out  4  one-hot index of the shown byte; bit 3 selects result[31:24].
- ready  out  1  high while a result is held.
- flags_o  out  5  class of the held word: [4]=sign, [3]=NaN, [2]=Inf, [1]=zero, [0]=denormal.

## Operation
- States: EMPTY and SHOW.
- EMPTY outputs: dataout=0x00, byteselect_o=4'b0000, ready=0, flags_o=0. nextpulse and autoscroll are ignored.
- Capture: resultvalid in either state registers `result`, sets the pointer to byte 3, clears the scroll counter, computes flags, and enters SHOW.
  - A capture while in SHOW overwrites the held word.
- Advance: in SHOW, nextpulse or a scroll tick moves the pointer 3→2→1→0→3 (wrap-around).
  - dataout = held[8*p+7 : 8*p].
  - byteselect_o = 1<<p.
- Flags, decoded from the held word (exp = [30:23], man = [22:0]); exactly one of NaN/Inf/zero/denormal or none:
  - NaN: exp=0xFF, man≠0.
  - Inf: exp=0xFF, man=0.
  - zero: exp=0, man=0.
  - denormal: exp=0, man≠0.
  - sign: bit 31, reported for every class.
- Scroll counter:
  - Counts only in SHOW with autoscroll=1. Held at 0 otherwise.
  - Tick when the count reaches SCROLL_TICKS-1; the count then wraps to 0.
  - Also reset to 0 by nextpulse and by capture.
- Simultaneous events:
  - Priority: capture > clear > advance.
  - resultvalid+clearpulse → capture.
  - nextpulse and a tick in the same cycle → a single advance.
- clearpulse in SHOW → EMPTY. The held register is zeroed.

## Timing
- All outputs are driven from registers; there is no combinational path from inputs to outputs.
- Capture latency is one edge: resultvalid sampled at edge N → at edge N the outputs show byte 3, ready=1, and flags are valid.
- Advance latency is one edge after nextpulse, or after the tick count reaches SCROLL_TICKS-1.
- With autoscroll held at 1 and no pulses, consecutive advances are exactly SCROLL_TICKS cycles apart.
- Reset (asynchronous assert, at any time including mid-SHOW):
  - State → EMPTY.
  - Pointer, counter, held word and flags → 0.
  - All outputs take their EMPTY values immediately, without waiting for a clock edge.
- After reset deasserts, the first capture behaves normally.

## Structure
- Shared package peripheral_pkg holds:
  - the state enum (EMPTY, SHOW);
  - NUM_BYTES=4;
  - flag bit positions (FLAG_SIGN=4 … FLAG_DENORM=0);
  - EXP_ALL_ONES=8'hFF.
- One sub-module, peripheral_scrolltick:
  - parameterised by SCROLL_TICKS;
  - inputs: enable and clear;
  - output: a one-cycle tick.
- The top level contains the FSM, the held register, the pointer, and the flag decoder.

## Test plan
- Reset, then capture 0x40490FDB → dataout=0x40, byteselect_o=1000, ready=1, flags=00000. Then 4 nextpulses → 0x49/0100, 0x0F/0010, 0xDB/0001, then wrap to 0x40/1000.
- Capture 0x7F800000 → flags=00100. Capture 0xFFC00000 → flags=11000. Capture 0x80000000 → flags=10010. Capture 0x00000001 → flags=00001.
- SCROLL_TICKS=4, autoscroll=1 after capturing 0x11223344 → dataout steps 0x11→0x22→0x33→0x44→0x11, one step every 4 cycles. A nextpulse mid-count advances immediately and restarts the 4-cycle spacing.
- resultvalid and clearpulse in the same cycle with result=0xAABBCCDD → SHOW, dataout=0xAA. Next, clearpulse alone → dataout=0x00, byteselect_o=0000, ready=0. A nextpulse while EMPTY has no effect.
- While in SHOW on byte 1, assert reset between clock edges → outputs go to 0 before the next edge. After release, capture 0x3F800000 → dataout=0x3F, byteselect_o=1000.
- resultvalid with 0x12345678 while showing byte 0 of a previous word, coincident with nextpulse → dataout=0x12, byteselect_o=1000.
